interface_ov7670_uc: RTL and testbench

Control unit for the OV7670 capture datapath. On `iniciar` it clears all datapath counters and sends the 0xFF trigger byte through the UART. It then consumes the camera's 2-byte-per-pixel serial stream, advancing the pixel counters once per pixel and storing the 9 sampled pixels selected by the datapath matchers. It sits between the top-level command logic and the capture datapath, driving every zera/conta/partida/we strobe.

---
 rtl/interface_ov7670_uc_if.sv | 43 ++++
 rtl/interface_ov7670_uc.sv | 145 ++++++++++++++
 tb/tb_interface_ov7670_uc.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/interface_ov7670_uc_if.sv
// Bus between the OV7670 capture control unit and its surroundings
// (start command, UART handshakes, datapath matchers and counter strobes).
// The control unit uses the master modport; the datapath/command side uses slave.
interface interface_ov7670_uc_if;
   // command, UART and datapath status towards the control unit
   logic       iniciar;
   logic       fim_transmissao;
   logic       fim_recepcao;
   logic       escreve_byte;
   logic       fim_coluna_pixel;
   logic [1:0] coluna_quadrante_addr;
   // strobes and status from the control unit
   logic       zera_linha_pixel;
   logic       zera_coluna_pixel;
   logic       zera_linha_quadrante;
   logic       zera_coluna_quadrante;
   logic       conta_coluna_pixel;
   logic       conta_coluna_quadrante;
   logic       conta_linha_quadrante;
   logic       we_byte;
   logic       partida_serial;
   logic       pronto;
   logic       erro;
   logic [3:0] db_estado;

   modport master (
      input  iniciar, fim_transmissao, fim_recepcao, escreve_byte,
             fim_coluna_pixel, coluna_quadrante_addr,
      output zera_linha_pixel, zera_coluna_pixel, zera_linha_quadrante,
             zera_coluna_quadrante, conta_coluna_pixel, conta_coluna_quadrante,
             conta_linha_quadrante, we_byte, partida_serial, pronto, erro,
             db_estado
   );

   modport slave (
      output iniciar, fim_transmissao, fim_recepcao, escreve_byte,
             fim_coluna_pixel, coluna_quadrante_addr,
      input  zera_linha_pixel, zera_coluna_pixel, zera_linha_quadrante,
             zera_coluna_quadrante, conta_coluna_pixel, conta_coluna_quadrante,
             conta_linha_quadrante, we_byte, partida_serial, pronto, erro,
             db_estado
   );
endinterface

// File: rtl/interface_ov7670_uc.sv
// Control unit for the OV7670 capture datapath: clears the counters, sends the
// 0xFF trigger byte, then walks the 2-byte-per-pixel camera stream, advancing
// the pixel column once per pixel and storing the pixels the datapath flags.
// Optional watchdog: define INTERFACE_UC_TIMEOUT_EN to send a stalled wait
// state to ERRO after TIMEOUT_CYCLES cycles.
module interface_ov7670_uc #(
   parameter int LINES          = 120,
   parameter int S_LINE         = 7,
   parameter int TIMEOUT_CYCLES = 500000
) (
   input  logic                  clock,
   input  logic                  reset,
   interface_ov7670_uc_if.master uc
);

   typedef enum logic [3:0] {
      INICIAL      = 4'd0,
      PREPARA      = 4'd1,
      ENVIA        = 4'd2,
      ESPERA_TX    = 4'd3,
      ESPERA_ALTO  = 4'd4,
      ESPERA_BAIXO = 4'd5,
      AVALIA       = 4'd6,
      ARMAZENA     = 4'd7,
      PROXIMO      = 4'd8,
      FIM          = 4'd9,
      ERRO         = 4'd10
   } state_t;

   state_t            state, next_state;
   logic [S_LINE-1:0] linha;
   logic              last_line;
   logic              timeout;

   assign last_line = (linha == S_LINE'(LINES - 1));

`ifdef INTERFACE_UC_TIMEOUT_EN
   localparam bit WATCHDOG_EN = 1'b1;
   logic [31:0] watchdog;

   assign timeout = (watchdog == 32'(TIMEOUT_CYCLES - 1));

   // Watchdog: restarts on every state change, counts cycles spent waiting.
   always_ff @(posedge clock) begin
      if (reset)
         watchdog <= '0;
      else if (next_state != state)
         watchdog <= '0;
      else if (state inside {ESPERA_TX, ESPERA_ALTO, ESPERA_BAIXO})
         watchdog <= watchdog + 32'd1;
   end
`else
   localparam bit WATCHDOG_EN = 1'b0;
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   assign timeout = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock) begin
      // NOTE: sequential state is always updated with <= so every register
      // samples pre-edge values regardless of block ordering.
      if (reset)
         state <= INICIAL;
      else
         state <= next_state;
   end

   // Frame line counter: cleared on a new capture, advanced at each line end.
   always_ff @(posedge clock) begin
      if (reset)
         linha <= '0;
      else if (state == PREPARA)
         linha <= '0;
      else if (state == PROXIMO && uc.fim_coluna_pixel && !last_line)
         linha <= linha + 1'b1;
   end

   // Next-state and Moore-decoded strobes.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      next_state               = state;
      uc.zera_linha_pixel      = 1'b0;
      uc.zera_coluna_pixel     = 1'b0;
      uc.zera_linha_quadrante  = 1'b0;
      uc.zera_coluna_quadrante = 1'b0;
      uc.conta_coluna_pixel    = 1'b0;
      uc.conta_coluna_quadrante = 1'b0;
      uc.conta_linha_quadrante = 1'b0;
      uc.we_byte               = 1'b0;
      uc.partida_serial        = 1'b0;
      uc.pronto                = 1'b0;
      uc.erro                  = 1'b0;
      uc.db_estado             = state;

      case (state)
         INICIAL: if (uc.iniciar) next_state = PREPARA;
         PREPARA: begin
            uc.zera_linha_pixel      = 1'b1;
            uc.zera_coluna_pixel     = 1'b1;
            uc.zera_linha_quadrante  = 1'b1;
            uc.zera_coluna_quadrante = 1'b1;
            next_state               = ENVIA;
         end
         ENVIA: begin
            uc.partida_serial = 1'b1;
            next_state        = ESPERA_TX;
         end
         ESPERA_TX: begin
            if (uc.fim_transmissao) next_state = ESPERA_ALTO;
            else if (timeout)       next_state = ERRO;
         end
         ESPERA_ALTO: begin
            if (uc.fim_recepcao) next_state = ESPERA_BAIXO;
            else if (timeout)    next_state = ERRO;
         end
         ESPERA_BAIXO: begin
            if (uc.fim_recepcao) next_state = AVALIA;
            else if (timeout)    next_state = ERRO;
         end
         AVALIA: next_state = uc.escreve_byte ? ARMAZENA : PROXIMO;
         ARMAZENA: begin
            uc.we_byte                = 1'b1;
            uc.conta_coluna_quadrante = 1'b1;
            uc.conta_linha_quadrante  = (uc.coluna_quadrante_addr == 2'd2);
            next_state                = PROXIMO;
         end
         PROXIMO: begin
            uc.conta_coluna_pixel = 1'b1;
            if (uc.fim_coluna_pixel && last_line) next_state = FIM;
            else                                  next_state = ESPERA_ALTO;
         end
         FIM: begin
            uc.pronto = 1'b1;
            if (uc.iniciar) next_state = PREPARA;
         end
         ERRO: begin
            uc.erro = WATCHDOG_EN;
            if (uc.iniciar) next_state = PREPARA;
         end
         default: next_state = INICIAL;
      endcase
   end

endmodule

// File: tb/tb_interface_ov7670_uc.sv
// Self-checking bench for interface_ov7670_uc: directed start/skip/store/frame
// sequences plus randomized frames scored against a per-pixel reference model.
// Honours INTERFACE_UC_TIMEOUT_EN for the watchdog expectations.
module tb_interface_ov7670_uc;

   localparam int LINES   = 2;
   localparam int TIMEOUT = 16;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   interface_ov7670_uc_if bus ();

   interface_ov7670_uc #(
      .LINES(LINES),
      .S_LINE(7),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clock(clock),
      .reset(reset),
      .uc(bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state: lines completed in the current frame
   int lines_done = 0;
   bit frame_done = 1'b0;

   logic [10:0] outs_vec;
   logic [3:0]  zeras;
   assign zeras = {bus.zera_linha_pixel, bus.zera_coluna_pixel,
                   bus.zera_linha_quadrante, bus.zera_coluna_quadrante};
   assign outs_vec = {zeras, bus.conta_coluna_pixel, bus.conta_coluna_quadrante,
                      bus.conta_linha_quadrante, bus.we_byte, bus.partida_serial,
                      bus.pronto, bus.erro};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // From INICIAL, FIM or ERRO: run the trigger sequence and land in state 4.
   task automatic start_capture();
      int gap;
      bus.iniciar = 1'b1;
      tick();
      bus.iniciar = 1'b0;
      check("prepara_state", bus.db_estado, 1);
      check("prepara_zera", zeras, 4'hF);
      check("prepara_partida", bus.partida_serial, 0);
      tick();
      check("envia_state", bus.db_estado, 2);
      check("envia_partida", bus.partida_serial, 1);
      check("envia_zera", zeras, 0);
      tick();
      check("espera_tx_state", bus.db_estado, 3);
      check("espera_tx_partida", bus.partida_serial, 0);
      gap = $urandom_range(1, 4);
      bus.fim_recepcao = 1'b1;           // must be ignored while waiting for TX
      tick();
      bus.fim_recepcao = 1'b0;
      for (int i = 1; i < gap; i++) tick();
      check("espera_tx_hold", bus.db_estado, 3);
      bus.fim_transmissao = 1'b1;
      tick();
      bus.fim_transmissao = 1'b0;
      check("espera_alto_state", bus.db_estado, 4);
      lines_done = 0;
      frame_done = 1'b0;
   endtask

   // One camera pixel (two bytes) from state 4, scored against the model.
   task automatic send_pixel(input bit store, input bit fim_col, input logic [1:0] addr);
      int lat, n_col, n_we, n_cq, n_lq, n_lq_alone, exp_state;
      check("pixel_start_state", bus.db_estado, 4);
      bus.fim_recepcao = 1'b1;
      tick();
      bus.fim_recepcao = 1'b0;
      check("pixel_baixo_state", bus.db_estado, 5);
      repeat ($urandom_range(0, 3)) tick();
      bus.escreve_byte          = store;
      bus.fim_coluna_pixel      = fim_col;
      bus.coluna_quadrante_addr = addr;
      bus.fim_recepcao          = 1'b1;
      lat = 0; n_col = 0; n_we = 0; n_cq = 0; n_lq = 0; n_lq_alone = 0;
      for (int n = 1; n <= 6; n++) begin
         tick();
         if (n == 1) bus.fim_recepcao = 1'b0;
         if (bus.conta_coluna_pixel) begin
            if (lat == 0) lat = n;
            n_col++;
         end
         if (bus.we_byte) n_we++;
         if (bus.conta_coluna_quadrante) n_cq++;
         if (bus.conta_linha_quadrante) n_lq++;
         if (bus.conta_linha_quadrante && !bus.conta_coluna_quadrante) n_lq_alone++;
      end
      bus.escreve_byte          = 1'b0;
      bus.fim_coluna_pixel      = 1'b0;
      bus.coluna_quadrante_addr = 2'd0;

      if (fim_col && lines_done == LINES - 1) begin
         exp_state  = 9;
         frame_done = 1'b1;
      end else begin
         if (fim_col) lines_done++;
         exp_state = 4;
      end
      check("pixel_latency", lat, store ? 3 : 2);
      check("pixel_conta_col", n_col, 1);
      check("pixel_we", n_we, store ? 1 : 0);
      check("pixel_conta_cq", n_cq, store ? 1 : 0);
      check("pixel_conta_lq", n_lq, (store && addr == 2'd2) ? 1 : 0);
      check("pixel_lq_alone", n_lq_alone, 0);
      check("pixel_end_state", bus.db_estado, exp_state);
      check("pixel_pronto", bus.pronto, exp_state == 9 ? 1 : 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int cnt;
      bus.iniciar               = 1'b0;
      bus.fim_transmissao       = 1'b0;
      bus.fim_recepcao          = 1'b0;
      bus.escreve_byte          = 1'b0;
      bus.fim_coluna_pixel      = 1'b0;
      bus.coluna_quadrante_addr = 2'd0;
      reset                     = 1'b1;
      repeat (3) tick();
      reset = 1'b0;

      // reset / idle
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_state", bus.db_estado, 0);
         check("idle_outs", outs_vec, 0);
      end

      // start sequence, iniciar ignored mid-frame
      start_capture();
      bus.iniciar = 1'b1;
      tick();
      bus.iniciar = 1'b0;
      check("iniciar_ignored", bus.db_estado, 4);

      // skip, then three stores stepping the quadrant column 0,1,2
      send_pixel(1'b0, 1'b0, 2'd0);
      for (int a = 0; a < 3; a++) send_pixel(1'b1, 1'b0, 2'(a));

      // frame end with fim_coluna_pixel on every pixel
      send_pixel(1'b0, 1'b1, 2'd0);
      send_pixel(1'b1, 1'b1, 2'd1);
      repeat (3) tick();
      check("fim_hold_state", bus.db_estado, 9);
      check("fim_hold_pronto", bus.pronto, 1);

      // randomized frames
      for (int f = 0; f < 3; f++) begin
         start_capture();
         for (int p = 0; p < 60 && !frame_done; p++)
            send_pixel(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                       2'($urandom_range(0, 2)));
         check("random_frame_done", frame_done, 1);
      end

      // stall in state 4
      start_capture();
      cnt = 1;
      while (cnt < 40 && bus.db_estado == 4) begin
         tick();
         if (bus.db_estado == 4) cnt++;
      end
`ifdef INTERFACE_UC_TIMEOUT_EN
      check("timeout_cycles", cnt, TIMEOUT);
      check("timeout_state", bus.db_estado, 10);
      check("timeout_erro", bus.erro, 1);
`else
      check("stall_cycles", cnt, 40);
      check("stall_state", bus.db_estado, 4);
      check("stall_erro", bus.erro, 0);
`endif

      // reset from wherever the stall left us
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("reset_state", bus.db_estado, 0);
      check("reset_outs", outs_vec, 0);

      // mid-frame reset while waiting for the second byte
      start_capture();
      bus.fim_recepcao = 1'b1;
      tick();
      bus.fim_recepcao = 1'b0;
      check("midframe_state", bus.db_estado, 5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midframe_reset_state", bus.db_estado, 0);
      check("midframe_reset_erro", bus.erro, 0);
      tick();
      check("midframe_reset_idle", bus.db_estado, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
